pwm_multi: RTL and testbench

- Parametrised successor to the single-channel LED PWM: N independent channels share one period counter.
- Duty values are double-buffered, so a write takes effect only at a period boundary. This removes mid-period glitches on RGB LEDs.
- Sits between the SPI register decode (duty writes) and the LED pins.
- A true 0 % and a true 100 % duty are both reachable.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 61 ++++++
 rtl/pwm_multi.sv | 93 +++++++++
 tb/tb_pwm_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEF = 8;
  localparam int unsigned PWM_CH_DEF    = 3;

  typedef logic [PWM_WIDTH_DEF-1:0] pwm_duty_t;

  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty double buffer, pending flag and the
// registered compare against the shared next counter value.
module pwm_channel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             boundary,
  input  logic [WIDTH-1:0] cnt_next,
  input  logic             load,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             pending
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_pending;
  logic             r_pwm;
  logic [WIDTH-1:0] w_active_nxt;

  // A load landing on the boundary bypasses the shadow and wins over pending.
  always_comb begin
    w_active_nxt = r_active;
    if (boundary) begin
      if (load) begin
        w_active_nxt = duty_in;
      end else if (r_pending) begin
        w_active_nxt = r_shadow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (load) begin
        r_shadow <= duty_in;
      end
      if (boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
      // Compare against the duty that will be active, so the new period starts clean.
      if (tick) begin
        r_pwm <= (cnt_next < w_active_nxt);
      end
    end
  end

  assign pwm_out = r_pwm;
  assign pending = r_pending;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one period counter (0..2^WIDTH-2) with double-buffered duty.
// Optional tick prescaler enabled by defining PWM_PRESCALE_EN.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS   = PWM_CH_DEF,
  parameter int unsigned WIDTH      = PWM_WIDTH_DEF,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
`ifdef PWM_PRESCALE_EN
  input  logic [PRESCALE_W-1:0]     prescale,
`endif
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS-1:0]       pending,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(pwm_max(WIDTH) - 32'd1);

  if (CHANNELS < 1 || CHANNELS > 16 || WIDTH < 4 || WIDTH > 16 || PRESCALE_W < 1) begin : g_bad_param
    $error("pwm_multi: parameter out of range");
  end

  logic             w_tick;
  logic             w_boundary;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_cnt;
  logic             r_period_start;

`ifdef PWM_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_pre;

  assign w_tick = (r_pre == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= prescale;
    end else begin
      r_pre <= r_pre - 1'b1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_cnt_next = r_cnt;
    w_boundary = 1'b0;
    if (w_tick) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_period_start <= w_boundary;
    end
  end

  assign period_start = r_period_start;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (w_tick),
      .boundary (w_boundary),
      .cnt_next (w_cnt_next),
      .load     (load[c]),
      .duty_in  (duty_in[c*WIDTH +: WIDTH]),
      .pwm_out  (pwm_out[c]),
      .pending  (pending[c])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (default 3x8 instance plus a 1x4 instance).
module tb_pwm_multi;

  localparam int unsigned NONE = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  load = '0;
  logic [23:0] duty_in = '0;
  logic [2:0]  pwm_out;
  logic [2:0]  pending;
  logic        period_start;

  logic [0:0]  load4 = '0;
  logic [3:0]  duty4 = '0;
  logic [0:0]  pwm4;
  logic [0:0]  pend4;
  logic        ps4;

`ifdef PWM_PRESCALE_EN
  logic [7:0]  prescale = '0;
  logic [7:0]  prescale4 = '0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CHANNELS(3), .WIDTH(8), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .duty_in      (duty_in),
`ifdef PWM_PRESCALE_EN
    .prescale     (prescale),
`endif
    .pwm_out      (pwm_out),
    .pending      (pending),
    .period_start (period_start)
  );

  pwm_multi #(.CHANNELS(1), .WIDTH(4), .PRESCALE_W(8)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .load         (load4),
    .duty_in      (duty4),
`ifdef PWM_PRESCALE_EN
    .prescale     (prescale4),
`endif
    .pwm_out      (pwm4),
    .pending      (pend4),
    .period_start (ps4)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts on a period_start sample and runs until the next one, applying up to
  // two one-clk load events at the given sample indices.
  task automatic run_period(input int unsigned a1, input logic [2:0] m1, input logic [23:0] d1,
                            input int unsigned a2, input logic [2:0] m2, input logic [23:0] d2,
                            output int unsigned len, output int unsigned h0,
                            output int unsigned h1, output int unsigned h2,
                            output logic [2:0] first, output logic [2:0] pmid);
    len = 0; h0 = 0; h1 = 0; h2 = 0;
    first = pwm_out;
    pmid = '0;
    do begin
      if (len == a1 + 1) pmid = pending;
      h0 += 32'(pwm_out[0]);
      h1 += 32'(pwm_out[1]);
      h2 += 32'(pwm_out[2]);
      load = '0;
      if (len == a1) begin load = m1; duty_in = d1; end
      if (len == a2) begin load = m2; duty_in = d2; end
      len++;
      step();
    end while (!period_start && len < 5000);
    load = '0;
  endtask

  task automatic wait_ps(input string tag);
    int unsigned n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 5000);
    check(tag, 32'(period_start), 1);
  endtask

  int unsigned len, h0, h1, h2, n, hi;
  logic [2:0]  first, pmid, seen;

  initial begin
    step();
    step();
    rst = 1'b0;

    // Running state before a mid-period reset
    load = 3'b111; duty_in = 24'hFFFFFF;
    step();
    load = '0;
    check("pend_after_load", 32'(pending), 7);
    repeat (299) step();
    check("pwm_pre_reset", 32'(pwm_out), 7);

    rst = 1'b1;
    step();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_ps", 32'(period_start), 0);
    load = 3'b111; duty_in = 24'h123456;
    step();
    load = '0;
    step();
    check("rst_pwm_3clk", 32'(pwm_out), 0);
    check("rst_load_ignored", 32'(pending), 0);
    rst = 1'b0;

    n = 0; seen = '0;
    do begin
      step();
      n++;
      seen |= pwm_out;
    end while (!period_start && n < 400);
    check("first_ps_latency", n, 255);
    check("pwm_idle_after_rst", 32'(seen), 0);

    // Duty sweep: ch0=0, ch1=64, ch2=255
    run_period(0, 3'b111, 24'hFF4000, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("sweep_load_len", len, 255);
    check("sweep_pend_mid", 32'(pmid), 7);
    check("sweep_pend_boundary", 32'(pending), 0);
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("sweep_len", len, 255);
    check("sweep_first", 32'(first), 6);
    check("sweep_ch0_hi", h0, 0);
    check("sweep_ch1_hi", h1, 64);
    check("sweep_ch2_hi", h2, 255);

    // Double buffering: ch1 loaded with 200 at count 100
    run_period(100, 3'b010, 24'h00C800, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("dbuf_cur_ch1_hi", h1, 64);
    check("dbuf_pend_mid", 32'(pmid), 2);
    check("dbuf_pend_boundary", 32'(pending), 0);
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("dbuf_next_ch1_hi", h1, 200);
    check("dbuf_next_ch2_hi", h2, 255);

    // Load exactly on the wrap cycle
    run_period(254, 3'b001, 24'h00000A, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("coll_len", len, 255);
    check("coll_cur_ch0_hi", h0, 0);
    check("coll_pend", 32'(pending), 0);
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("coll_ch0_hi", h0, 10);
    check("coll_first_ch0", 32'(first[0]), 1);

    // Two loads in one period: last wins
    run_period(50, 3'b001, 24'h000007, 60, 3'b001, 24'h000009, len, h0, h1, h2, first, pmid);
    check("two_cur_ch0_hi", h0, 10);
    check("two_pend_mid", 32'(pmid), 1);
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("two_ch0_hi", h0, 9);

    // WIDTH=4 instance
    load4 = 1'b1; duty4 = 4'd15;
    step();
    load4 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!ps4 && n < 100);
    check("w4_ps_found", 32'(ps4), 1);
    len = 0; hi = 0;
    do begin hi += 32'(pwm4); len++; step(); end while (!ps4 && len < 100);
    check("w4_len", len, 15);
    check("w4_full_hi", hi, 15);
    load4 = 1'b1; duty4 = 4'd5;
    step();
    load4 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!ps4 && n < 100);
    len = 0; hi = 0;
    do begin hi += 32'(pwm4); len++; step(); end while (!ps4 && len < 100);
    check("w4_d5_hi", hi, 5);

`ifdef PWM_PRESCALE_EN
    wait_ps("pre_align");
    run_period(0, 3'b001, 24'h000080, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    prescale = 8'd3;
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("pre3_len", len, 1020);
    check("pre3_ch0_hi", h0, 512);
    repeat (100) step();
    prescale = 8'd0;
    wait_ps("pre0_found");
    run_period(NONE, '0, '0, NONE, '0, '0, len, h0, h1, h2, first, pmid);
    check("pre0_len", len, 255);
    check("pre0_ch0_hi", h0, 128);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
